fetch_stage: RTL and testbench

- Instruction-fetch stage of the pipelined 8-bit processor. Sits directly upstream of the decoder.
- Owns the program counter and drives the address of the combinational instruction memory.
- Registers each fetched instruction, with its PC and PC+1, into the IF/ID pipeline register consumed by ID.
- Applies branch redirects from EX, stalls from the hazard logic, and halt detection.

---
 rtl/fetch_stage_if.sv | 31 +++
 rtl/fetch_stage.sv | 100 ++++++++++
 tb/tb_fetch_stage.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Bundle between the fetch stage, instruction memory, hazard/branch logic and
// the IF/ID consumer. The master side is the fetch stage itself.
interface fetch_stage_if #(
  parameter int PC_WIDTH    = 10,
  parameter int INSTR_WIDTH = 16
);
  logic [INSTR_WIDTH-1:0] iInstruction;
  logic                   iStall;
  logic                   iBranchTaken;
  logic [PC_WIDTH-1:0]    iBranchTarget;
  logic [PC_WIDTH-1:0]    oAddressPC;
  logic [INSTR_WIDTH-1:0] oInstruction_ID;
  logic [PC_WIDTH-1:0]    oPC_ID;
  logic [PC_WIDTH-1:0]    oPCNext_ID;
  logic                   oValid_ID;
  logic                   oHalted;
  logic [15:0]            oFetchCount;
  logic [1:0]             dbgState;

  modport master (
    input  iInstruction, iStall, iBranchTaken, iBranchTarget,
    output oAddressPC, oInstruction_ID, oPC_ID, oPCNext_ID,
           oValid_ID, oHalted, oFetchCount, dbgState
  );

  modport slave (
    output iInstruction, iStall, iBranchTaken, iBranchTarget,
    input  oAddressPC, oInstruction_ID, oPC_ID, oPCNext_ID,
           oValid_ID, oHalted, oFetchCount, dbgState
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction-memory address and
// loads the IF/ID register, honouring branch redirects, stalls and halt.
module fetch_stage #(
  parameter int                  PC_WIDTH    = 10,
  parameter int                  INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [5:0]          HALT_OP     = 6'h3F
) (
  input logic          Clock,
  input logic          Reset,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {S_START, S_RUN, S_HALT} state_t;

  state_t                 state, stateNext;
  logic [PC_WIDTH-1:0]    pc, pcNext;
  logic [INSTR_WIDTH-1:0] instrId, instrIdNext;
  logic [PC_WIDTH-1:0]    pcId, pcIdNext;
  logic [PC_WIDTH-1:0]    pcPlusId, pcPlusIdNext;
  logic                   validId, validIdNext;
  logic                   halted;
  logic [15:0]            fetchCount, fetchCountNext;
  logic                   isHaltOp;

  // IF/ID handshake: oValid_ID=1 marks a real instruction for ID; iStall is the
  // downstream "not ready" and freezes both the PC and the IF/ID register.
  assign isHaltOp = (bus.iInstruction[INSTR_WIDTH-1 -: 6] == HALT_OP);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state      <= S_START;
      pc         <= RESET_PC;
      instrId    <= '0;
      pcId       <= '0;
      pcPlusId   <= '0;
      validId    <= 1'b0;
      halted     <= 1'b0;
      fetchCount <= '0;
    end else begin
      state      <= stateNext;
      pc         <= pcNext;
      instrId    <= instrIdNext;
      pcId       <= pcIdNext;
      pcPlusId   <= pcPlusIdNext;
      validId    <= validIdNext;
      halted     <= (stateNext == S_HALT);
      fetchCount <= fetchCountNext;
    end
  end

  always_comb begin
    stateNext      = state;
    pcNext         = pc;
    instrIdNext    = instrId;
    pcIdNext       = pcId;
    pcPlusIdNext   = pcPlusId;
    validIdNext    = validId;
    fetchCountNext = fetchCount;
    case (state)
      S_START: stateNext = S_RUN;
      S_RUN: begin
        if (bus.iBranchTaken) begin
          pcNext      = bus.iBranchTarget;
          validIdNext = 1'b0;
          instrIdNext = '0;
        end else if (!bus.iStall) begin
          instrIdNext    = bus.iInstruction;
          pcIdNext       = pc;
          pcPlusIdNext   = pc + 1'b1;
          validIdNext    = 1'b1;
          fetchCountNext = (fetchCount == 16'hFFFF) ? fetchCount : fetchCount + 16'd1;
          // The halt word itself is delivered; only the PC stops advancing.
          if (isHaltOp) stateNext = S_HALT;
          else          pcNext    = pc + 1'b1;
        end
      end
      S_HALT: begin
        if (bus.iBranchTaken) begin
          pcNext      = bus.iBranchTarget;
          validIdNext = 1'b0;
          stateNext   = S_RUN;
        end else if (!bus.iStall) begin
          validIdNext = 1'b0;
        end
      end
      default: stateNext = S_START;
    endcase
  end

  assign bus.oAddressPC      = pc;
  assign bus.oInstruction_ID = instrId;
  assign bus.oPC_ID          = pcId;
  assign bus.oPCNext_ID      = pcPlusId;
  assign bus.oValid_ID       = validId;
  assign bus.oHalted         = halted;
  assign bus.oFetchCount     = fetchCount;
  assign bus.dbgState        = state;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: behavioural model feeds an expected
// queue each cycle; DUT outputs are popped and compared after every edge.
module tb_fetch_stage;
  logic Clock;
  logic Reset;
  logic [15:0] mem [0:1023];

  fetch_stage_if #(.PC_WIDTH(10), .INSTR_WIDTH(16)) bus ();

  fetch_stage dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  assign bus.iInstruction = mem[bus.oAddressPC];

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  // Behavioural model state
  logic [1:0]  mState;  // 0 start, 1 run, 2 halt
  logic [9:0]  mPc, mPcId, mPcNext;
  logic [15:0] mInstr, mCount;
  logic        mValid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mState = 2'd0; mPc = 10'd0; mPcId = 10'd0; mPcNext = 10'd0;
    mInstr = 16'd0; mCount = 16'd0; mValid = 1'b0;
  endtask

  task automatic model_step(input logic stall, input logic br, input logic [9:0] tgt);
    logic [15:0] word;
    word = mem[mPc];
    case (mState)
      2'd0: mState = 2'd1;
      2'd1: begin
        if (br) begin
          mPc = tgt; mValid = 1'b0; mInstr = 16'd0;
        end else if (!stall) begin
          mInstr = word; mPcId = mPc; mPcNext = mPc + 10'd1; mValid = 1'b1;
          if (mCount != 16'hFFFF) mCount = mCount + 16'd1;
          if (word[15:10] == 6'h3F) mState = 2'd2;
          else mPc = mPc + 10'd1;
        end
      end
      default: begin
        if (br) begin
          mPc = tgt; mValid = 1'b0; mState = 2'd1;
        end else if (!stall) begin
          mValid = 1'b0;
        end
      end
    endcase
  endtask

  task automatic cycle(input logic stall, input logic br, input logic [9:0] tgt);
    logic [63:0] e;
    bus.iStall = stall;
    bus.iBranchTaken = br;
    bus.iBranchTarget = br ? tgt : 10'bx;
    model_step(stall, br, tgt);
    exp_q.push_back({mValid, (mState == 2'd2), mPc, mPcId, mPcNext, mInstr, mCount});
    @(posedge Clock);
    #1;
    e = exp_q.pop_front();
    check("valid",   {31'd0, bus.oValid_ID},      {31'd0, e[63]});
    check("halted",  {31'd0, bus.oHalted},        {31'd0, e[62]});
    check("addr",    {22'd0, bus.oAddressPC},     {22'd0, e[61:52]});
    check("pc_id",   {22'd0, bus.oPC_ID},         {22'd0, e[51:42]});
    check("pcnext",  {22'd0, bus.oPCNext_ID},     {22'd0, e[41:32]});
    check("instr",   {16'd0, bus.oInstruction_ID}, {16'd0, e[31:16]});
    check("count",   {16'd0, bus.oFetchCount},    {16'd0, e[15:0]});
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_addr"},   {22'd0, bus.oAddressPC},      32'd0);
    check({tag, "_instr"},  {16'd0, bus.oInstruction_ID}, 32'd0);
    check({tag, "_pc_id"},  {22'd0, bus.oPC_ID},          32'd0);
    check({tag, "_pcnext"}, {22'd0, bus.oPCNext_ID},      32'd0);
    check({tag, "_valid"},  {31'd0, bus.oValid_ID},       32'd0);
    check({tag, "_halted"}, {31'd0, bus.oHalted},         32'd0);
    check({tag, "_count"},  {16'd0, bus.oFetchCount},     32'd0);
    check({tag, "_state"},  {30'd0, bus.dbgState},        32'd0);
  endtask

  initial begin
    logic [15:0] base;
    base = 16'h0100;
    for (int i = 0; i < 1024; i++) mem[i] = base + 16'(i);
    mem[7] = 16'hFC00;

    // Clock/reset
    Reset = 1'b0;
    bus.iStall = 1'b0;
    bus.iBranchTaken = 1'b0;
    bus.iBranchTarget = 10'd0;
    model_reset();
    #22;
    check_reset_values("rst");
    #1 Reset = 1'b1;

    cycle(0, 0, 0);                 // S_START bubble
    repeat (5) cycle(0, 0, 0);      // fetch PCs 0..4
    repeat (3) cycle(1, 0, 0);      // stall at PC 5
    check("stall_addr", {22'd0, bus.oAddressPC}, 32'd5);
    repeat (3) cycle(0, 0, 0);      // PCs 5, 6 and the halt at 7
    check("halt_addr", {22'd0, bus.oAddressPC}, 32'd7);
    cycle(1, 0, 0);                 // halt held valid under stall
    cycle(0, 0, 0);                 // delivered once, then bubble
    cycle(0, 0, 0);
    cycle(0, 1, 10'd3);             // wrong-path halt cancelled
    repeat (2) cycle(0, 0, 0);
    cycle(1, 1, 10'h200);           // branch beats stall
    check("br_addr", {22'd0, bus.oAddressPC}, 32'h200);
    cycle(0, 0, 0);
    check("br_pc_id", {22'd0, bus.oPC_ID}, 32'h200);
    cycle(0, 1, 10'h3FE);
    cycle(0, 0, 0);
    cycle(0, 0, 0);                 // fetch at 0x3FF wraps
    check("wrap_pcnext", {22'd0, bus.oPCNext_ID}, 32'd0);
    check("wrap_addr", {22'd0, bus.oAddressPC}, 32'd0);
    cycle(0, 0, 0);

    // Random stall/branch traffic, targets near the halt word
    for (int n = 0; n < 80; n++) begin
      logic s, b;
      logic [9:0] t;
      s = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 7) == 0);
      t = 10'($urandom_range(0, 15));
      cycle(s, b, t);
    end

    // Asynchronous reset between edges
    #3 Reset = 1'b0;
    #1;
    check_reset_values("async_rst");
    model_reset();
    #2 Reset = 1'b1;
    cycle(0, 0, 0);
    repeat (4) cycle(0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
